seg7_scan_ctrl: RTL and testbench
=================================

Name: seg7_scan_ctrl

Overview:
- Time-multiplexed scan controller for a multi-digit 7-segment display built on the team's BCD-to-7-segment decoder.
- Holds a double-buffered frame of BCD digits and per-digit mode bits, and sequences one digit per time slot.
- Drives the shared decoder's bcd/mode inputs and a one-hot digit-enable bus, with dead-time between slots to suppress ghosting.
- Sits between the CPU/output register logic (load handshake) and the display pins.

Parameters:
- NUM_DIGITS, 4: number of digits scanned. Must be >= 2.
- SCAN_DIV, 1000: clock cycles per digit slot. Must be > BLANK_CYCLES.
- BLANK_CYCLES, 2: dead-time cycles at the start of each slot, during which all digit enables are low. Must be >= 1.

Ports:
- clk  in  1  system clock; all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- load_valid  in  1  a new frame is offered.
- load_ready  out  1  the controller can accept a frame.
- load_data  in  4*NUM_DIGITS  BCD digits; digit i is bits [4i+3:4i]; digit NUM_DIGITS-1 is the most significant.
- load_mode  in  NUM_DIGITS  per-digit decoder mode: 1 = show value, 0 = dash.
- lz_en  in  1  leading-zero suppression enable. Level input, evaluated live.
- bcd  out  4  to decoder bcd input.
- mode  out  1  to decoder mode input.
- digit_en  out  NUM_DIGITS  one-hot active-high digit select.
- cur_digit  out  $clog2(NUM_DIGITS)  index of the digit in the current slot.
- frame_done  out  1  one-cycle pulse at the end of each full scan.

Behaviour:
- Reset values when rst=1 at a clock edge:
  - State BLANK; slot counter 0; idx 0.
  - Active data and shadow data all 0; active mode and shadow mode all 0, so the display shows dashes.
  - pending=0, load_ready=1, digit_en=0, bcd=0, mode=0, cur_digit=0, frame_done=0.
- All outputs are registered.
- Reset mid-slot or mid-load aborts immediately; any pending frame is discarded.
- FSM, BLANK state:
  - digit_en=0; runs BLANK_CYCLES cycles.
  - bcd/mode/cur_digit already present the values for digit idx.
  - Then goes to SHOW.
- FSM, SHOW state:
  - digit_en=(1<<idx), unless the digit is suppressed, in which case digit_en=0; runs SCAN_DIV-BLANK_CYCLES cycles.
  - Then idx increments, wrapping NUM_DIGITS-1 -> 0, and the FSM returns to BLANK.
- Slot length is exactly SCAN_DIV cycles; frame length is exactly NUM_DIGITS*SCAN_DIV cycles.
- After reset release, the first SCAN_DIV cycles belong to digit 0.
- frame_done:
  - Asserted for exactly one cycle: the first BLANK cycle of digit 0 after the last SHOW cycle of digit NUM_DIGITS-1.
  - Not asserted for the first frame after reset.
- Load handshake:
  - A transfer occurs when load_valid && load_ready at a clock edge.
  - On transfer, load_data and load_mode are captured into the shadow registers, pending is set, and load_ready=0 from the next cycle.
  - While pending=1, load_valid is ignored and the shadow is held.
- Commit:
  - On the edge that ends the last SHOW cycle of digit NUM_DIGITS-1, if pending=1: active <= shadow, pending <= 0, and load_ready=1 on the following cycle.
  - New data is therefore first displayed in digit 0's slot of the next frame. No tearing within a frame.
- Simultaneous events:
  - A transfer on the frame-wrap edge itself is not committed on that edge (pending was 0 when sampled). It commits at the next frame end.
- Leading-zero suppression:
  - Digit i > 0 is suppressed when lz_en=1 and, for every j >= i, active mode[j]=1 and active data[j]=0.
  - Digit 0 is never suppressed.
  - A dash digit (mode 0) stops suppression for itself and all lower digits.
  - bcd/mode still carry the digit's values when it is suppressed; only digit_en is gated.
- Invalid BCD (10-15): passed through unchanged; the decoder blanks the segments. It counts as nonzero for suppression.

Test Plan:
(Parameters for all scenarios: NUM_DIGITS=4, SCAN_DIV=8, BLANK_CYCLES=2.)
1. Reset, then idle 64 cycles:
   - digit_en follows 0,0,0001×6, 0,0,0010×6, 0,0,0100×6, 0,0,1000×6, repeating.
   - mode=0 throughout.
   - frame_done pulses at cycles 32 and 64 only.
2. Load data 0x1234, mode 4'b1111, mid-frame:
   - load_ready drops the next cycle.
   - Old dashes remain until the frame end.
   - Next frame shows bcd 4,3,2,1 in slots 0-3.
   - load_ready returns high one cycle after the commit.
3. Hold load_valid high during pending, with a different data value:
   - Only the first value is committed.
   - The second transfer occurs once load_ready=1.
4. Load 0x0050, mode 4'b1111, lz_en=1:
   - digit_en is never high for digits 3 and 2.
   - Digits 1 and 0 are shown.
   - Repeat with mode 4'b0111: digit 3 shows a dash (mode=0) and digits 2 to 0 are all enabled.
5. Load accepted exactly on the frame-wrap edge:
   - Not displayed in the following frame; displayed in the frame after.
6. Assert rst during the SHOW of digit 2 with a frame pending:
   - Next cycle: digit_en=0, load_ready=1, idx=0.
   - Pending frame is never displayed; display shows dashes.

Source files
------------

// File: rtl/seg7_scan_ctrl.sv
//------------------------------------------------------------------------------
// seg7_scan_ctrl
//   Time-multiplexed scan controller for a multi-digit 7-segment display.
//   Double-buffered BCD frame with per-digit mode, dead-time between slots,
//   leading-zero suppression, and a valid/ready frame load handshake.
//   Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module seg7_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 1000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          load_valid,
  output logic                          load_ready,
  input  logic [4*NUM_DIGITS-1:0]       load_data,
  input  logic [NUM_DIGITS-1:0]         load_mode,
  input  logic                          lz_en,
  output logic [3:0]                    bcd,
  output logic                          mode,
  output logic [NUM_DIGITS-1:0]         digit_en,
  output logic [$clog2(NUM_DIGITS)-1:0] cur_digit,
  output logic                          frame_done
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int CNT_W = $clog2(SCAN_DIV);

  typedef enum logic [0:0] {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

  state_t                  state;
  logic [CNT_W-1:0]        cnt;       // cycle position within the current slot
  logic [IDX_W-1:0]        idx;
  logic [4*NUM_DIGITS-1:0] act_data;
  logic [NUM_DIGITS-1:0]   act_mode;
  logic [4*NUM_DIGITS-1:0] shadow_data;
  logic [NUM_DIGITS-1:0]   shadow_mode;
  logic                    pending;

  logic                    blank_end;
  logic                    slot_end;
  logic                    frame_end;
  logic                    commit;
  logic                    nxt_show;
  logic [IDX_W-1:0]        nxt_idx;
  logic [4*NUM_DIGITS-1:0] nxt_data;
  logic [NUM_DIGITS-1:0]   nxt_mode;
  logic [NUM_DIGITS-1:0]   nxt_onehot;
  logic [NUM_DIGITS-1:0]   sup;
  logic                    zero_run;

  // Slot/frame boundary decode and the view of the next cycle's digit and frame
  always_comb begin
    blank_end  = (state == ST_BLANK) && (cnt == CNT_W'(BLANK_CYCLES - 1));
    slot_end   = (state == ST_SHOW)  && (cnt == CNT_W'(SCAN_DIV - 1));
    frame_end  = slot_end && (idx == IDX_W'(NUM_DIGITS - 1));
    commit     = frame_end && pending;
    nxt_idx    = idx;
    if (slot_end) begin
      nxt_idx = (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
    end
    nxt_data   = commit ? shadow_data : act_data;
    nxt_mode   = commit ? shadow_mode : act_mode;
    nxt_show   = blank_end || ((state == ST_SHOW) && !slot_end);
    nxt_onehot = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << nxt_idx;
  end

  // Leading-zero suppression: walk down from the MSD while digits are shown zeros
  always_comb begin
    zero_run = 1'b1;
    sup      = '0;
    for (int j = NUM_DIGITS - 1; j >= 0; j--) begin
      zero_run = zero_run && nxt_mode[j] && (nxt_data[4*j +: 4] == 4'd0);
      if (j > 0) begin
        sup[j] = zero_run && lz_en;
      end
    end
  end

  // Scan FSM, frame buffers, handshake and registered display outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_BLANK;
      cnt         <= '0;
      idx         <= '0;
      act_data    <= '0;
      act_mode    <= '0;
      shadow_data <= '0;
      shadow_mode <= '0;
      pending     <= 1'b0;
      load_ready  <= 1'b1;
      digit_en    <= '0;
      bcd         <= 4'd0;
      mode        <= 1'b0;
      cur_digit   <= '0;
      frame_done  <= 1'b0;
    end else begin
      case (state)
        ST_BLANK: begin
          cnt <= cnt + 1'b1;
          if (blank_end) begin
            state <= ST_SHOW;
          end
        end
        ST_SHOW: begin
          if (slot_end) begin
            cnt   <= '0;
            state <= ST_BLANK;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          cnt   <= '0;
          state <= ST_BLANK;
        end
      endcase

      idx      <= nxt_idx;
      act_data <= nxt_data;
      act_mode <= nxt_mode;

      // Commit and transfer are exclusive: a transfer needs pending=0
      if (commit) begin
        pending    <= 1'b0;
        load_ready <= 1'b1;
      end else if (load_valid && load_ready) begin
        shadow_data <= load_data;
        shadow_mode <= load_mode;
        pending     <= 1'b1;
        load_ready  <= 1'b0;
      end

      digit_en   <= (nxt_show && !sup[nxt_idx]) ? nxt_onehot : '0;
      bcd        <= nxt_data[4*int'(nxt_idx) +: 4];
      mode       <= nxt_mode[nxt_idx];
      cur_digit  <= nxt_idx;
      frame_done <= frame_end;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seg7_scan_ctrl.sv
//------------------------------------------------------------------------------
// tb_seg7_scan_ctrl
//   Self-checking bench for seg7_scan_ctrl (NUM_DIGITS=4, SCAN_DIV=8,
//   BLANK_CYCLES=2) against a cycle-index based reference model.
//   Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_seg7_scan_ctrl;

  localparam int N = 4;
  localparam int S = 8;
  localparam int B = 2;
  localparam int F = N * S;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [15:0] load_data = 16'h0;
  logic [3:0]  load_mode = 4'h0;
  logic        lz_en = 1'b0;
  logic [3:0]  bcd;
  logic        mode;
  logic [3:0]  digit_en;
  logic [1:0]  cur_digit;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seg7_scan_ctrl #(.NUM_DIGITS(N), .SCAN_DIV(S), .BLANK_CYCLES(B)) dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .load_mode(load_mode), .lz_en(lz_en),
    .bcd(bcd), .mode(mode), .digit_en(digit_en), .cur_digit(cur_digit),
    .frame_done(frame_done)
  );

  // Reference model: cycle index since reset plus frame buffers
  int          m_t;
  logic [15:0] m_ad, m_sd;
  logic [3:0]  m_am, m_sm;
  logic        m_pend, m_lz;

  always @(posedge clk) begin
    if (rst) begin
      m_t <= 0; m_ad <= '0; m_am <= '0; m_sd <= '0; m_sm <= '0;
      m_pend <= 1'b0; m_lz <= lz_en;
    end else begin
      m_t  <= m_t + 1;
      m_lz <= lz_en;
      if (((m_t + 1) % F == 0) && m_pend) begin
        m_ad <= m_sd; m_am <= m_sm; m_pend <= 1'b0;
      end else if (load_valid && !m_pend) begin
        m_sd <= load_data; m_sm <= load_mode; m_pend <= 1'b1;
      end
    end
  end

  function automatic logic [12:0] exp_vec();
    int       i, ph;
    logic     s;
    logic [3:0] en;
    i  = (m_t / S) % N;
    ph = m_t % S;
    s  = (i > 0) && m_lz;
    for (int j = i; j < N; j++) begin
      if (!(m_am[j] && (m_ad[4*j +: 4] == 4'd0))) s = 1'b0;
    end
    en = (ph >= B && !s) ? 4'(1 << i) : 4'd0;
    return {en, m_ad[4*i +: 4], m_am[i], 2'(i), (m_t > 0 && m_t % F == 0), !m_pend};
  endfunction

  wire [12:0] obs = {digit_en, bcd, mode, cur_digit, frame_done, load_ready};

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Waits until the model can accept, aligns to a frame phase, pulses valid
  task automatic load_frame(input logic [15:0] d, input logic [3:0] md, input int phase);
    for (int k = 0; k < 3 * F && m_pend; k++) tick();
    for (int k = 0; k < F && (m_t % F != phase); k++) tick();
    load_data = d; load_mode = md; load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    checks++;
    if ({digit_en, bcd, mode, cur_digit, frame_done, load_ready} !== 13'b0000_0000_0_00_0_1) begin
      errors++;
      $display("FAIL reset_outputs got=%b exp=%b", obs, 13'b0000_0000_0_00_0_1);
    end
    rst = 1'b0;
  endtask

  task automatic test_idle();
    int pulses = 0;
    int bad_mode = 0;
    for (int k = 1; k <= 64; k++) begin
      tick();
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL idle_model cyc=%0d got=%h exp=%h", k, obs, exp_vec());
      end
      if (frame_done) begin
        pulses++;
        checks++;
        if (k != 32 && k != 64) begin
          errors++;
          $display("FAIL idle_frame_done_pos got=%0d exp=32_or_64", k);
        end
      end
      if (mode !== 1'b0) bad_mode++;
    end
    checks++;
    if (pulses != 2) begin
      errors++;
      $display("FAIL idle_frame_done_count got=%0d exp=2", pulses);
    end
    checks++;
    if (bad_mode != 0) begin
      errors++;
      $display("FAIL idle_mode_nonzero got=%0d exp=0", bad_mode);
    end
  endtask

  task automatic test_load();
    load_frame(16'h1234, 4'hF, 11);
    checks++;
    if (load_ready !== 1'b0) begin
      errors++;
      $display("FAIL load_ready_drop got=%b exp=0", load_ready);
    end
    for (int k = 0; k < 2 * F; k++) begin
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL load_model t=%0d got=%h exp=%h", m_t, obs, exp_vec());
      end
      if (m_t % F == B + S * 3 && k > F) begin
        checks++;
        if (bcd !== 4'h1) begin
          errors++;
          $display("FAIL load_msd_value got=%h exp=1", bcd);
        end
      end
      tick();
    end
  endtask

  task automatic test_hold();
    bit seen8 = 0, seen9 = 0;
    load_frame(16'h5678, 4'hF, 5);
    load_valid = 1'b1; load_data = 16'h9999;
    for (int k = 0; k < 4 * F; k++) begin
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL hold_model t=%0d got=%h exp=%h", m_t, obs, exp_vec());
      end
      if (digit_en[0] && bcd == 4'h8) seen8 = 1;
      if (digit_en[0] && bcd == 4'h9) seen9 = 1;
      tick();
    end
    load_valid = 1'b0;
    checks++;
    if (!(seen8 && seen9)) begin
      errors++;
      $display("FAIL hold_sequence got=%0d%0d exp=11", seen8, seen9);
    end
  endtask

  task automatic test_lzs();
    int cnt_en [4];
    int dash3;
    lz_en = 1'b1;
    for (int pass = 0; pass < 2; pass++) begin
      load_frame(16'h0050, (pass == 0) ? 4'hF : 4'h7, 3);
      for (int k = 0; k < F && (m_t % F != 0); k++) tick();
      for (int d = 0; d < 4; d++) cnt_en[d] = 0;
      dash3 = 0;
      for (int k = 0; k < F; k++) begin
        checks++;
        if (obs !== exp_vec()) begin
          errors++;
          $display("FAIL lzs_model t=%0d got=%h exp=%h", m_t, obs, exp_vec());
        end
        for (int d = 0; d < 4; d++) if (digit_en[d]) cnt_en[d]++;
        if (cur_digit == 2'd3 && mode == 1'b0) dash3++;
        tick();
      end
      for (int d = 0; d < 4; d++) begin
        checks++;
        if (cnt_en[d] != ((pass == 0 && d >= 2) ? 0 : S - B)) begin
          errors++;
          $display("FAIL lzs_enable_count pass=%0d digit=%0d got=%0d exp=%0d", pass, d,
                   cnt_en[d], (pass == 0 && d >= 2) ? 0 : S - B);
        end
      end
      checks++;
      if (dash3 != ((pass == 0) ? 0 : S)) begin
        errors++;
        $display("FAIL lzs_dash_digit3 pass=%0d got=%0d exp=%0d", pass, dash3, (pass == 0) ? 0 : S);
      end
    end
    lz_en = 1'b0;
  endtask

  task automatic test_wrap();
    logic [3:0] old0;
    for (int k = 0; k < 3 * F && m_pend; k++) tick();
    old0 = m_ad[3:0];
    load_frame(16'h9876, 4'hF, F - 1);
    checks++;
    if (load_ready !== 1'b0) begin
      errors++;
      $display("FAIL wrap_transfer got=%b exp=0", load_ready);
    end
    for (int k = 0; k < 2 * F; k++) begin
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL wrap_model t=%0d got=%h exp=%h", m_t, obs, exp_vec());
      end
      if (m_t % F == B) begin
        checks++;
        if (bcd !== ((k < F) ? old0 : 4'h6)) begin
          errors++;
          $display("FAIL wrap_digit0 k=%0d got=%h exp=%h", k, bcd, (k < F) ? old0 : 4'h6);
        end
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    int bad_mode = 0;
    load_frame(16'h4321, 4'hF, 3);
    for (int k = 0; k < F && (m_t % F != 2 * S + 4); k++) tick();
    rst = 1'b1;
    tick();
    checks++;
    if ({digit_en, load_ready, cur_digit, frame_done} !== 8'b0000_1_00_0) begin
      errors++;
      $display("FAIL reset_mid got=%b exp=%b", {digit_en, load_ready, cur_digit, frame_done}, 8'b0000_1_00_0);
    end
    rst = 1'b0;
    for (int k = 0; k < 2 * F; k++) begin
      tick();
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL reset_mid_model t=%0d got=%h exp=%h", m_t, obs, exp_vec());
      end
      if (mode !== 1'b0) bad_mode++;
    end
    checks++;
    if (bad_mode != 0) begin
      errors++;
      $display("FAIL reset_mid_dashes got=%0d exp=0", bad_mode);
    end
  endtask

  task automatic test_random();
    logic [15:0] d;
    for (int k = 0; k < 1500; k++) begin
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL random_model t=%0d got=%h exp=%h", m_t, obs, exp_vec());
      end
      for (int j = 0; j < 4; j++) d[4*j +: 4] = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
      load_data  = d;
      load_mode  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      load_valid = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 19) == 0) lz_en = ~lz_en;
      tick();
    end
    load_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_idle();
    test_load();
    test_hold();
    test_lzs();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
